// File: rtl/hourly_chime_pkg.sv
// Shared types and BCD constants for the hourly chime: FSM encoding and the trigger times.
package hourly_chime_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEEP_LO = 2'd1,
    BEEP_HI = 2'd2
  } chime_state_t;

  localparam logic [6:0] MIN_59 = 7'h59;
  localparam logic [6:0] MIN_00 = 7'h00;
  localparam logic [6:0] SEC_00 = 7'h00;

  localparam int N_LO_SECS = 4;
  localparam logic [N_LO_SECS-1:0][6:0] CHIME_LO_SECS = {7'h57, 7'h55, 7'h53, 7'h51};

  // Which beep a given accepted mm:ss asks for; IDLE means none (including non-BCD codes).
  function automatic chime_state_t chime_trigger(input logic [6:0] mm, input logic [6:0] ss);
    chime_state_t t;
    t = IDLE;
    if (mm == MIN_59) begin
      for (int i = 0; i < N_LO_SECS; i++) begin
        if (ss == CHIME_LO_SECS[i]) t = BEEP_LO;
      end
    end else if ((mm == MIN_00) && (ss == SEC_00)) begin
      t = BEEP_HI;
    end
    return t;
  endfunction

endpackage

// File: rtl/hourly_chime_bcd_sync_stable.sv
// Two-flop synchroniser plus an equal-twice filter for a multi-bit asynchronous value.
// Emits the accepted value and a one-clock pulse when its low CW bits change (never for the first one).
module hourly_chime_bcd_sync_stable #(
  parameter int W  = 14,
  parameter int CW = W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] value_o,
  output logic         change_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] acc_q;
  logic [2:0]   vld_q;
  logic         first_seen_q;
  logic         change_q;
  logic         stable;

  // vld_q keeps the reset-cleared pipeline zeros from passing as a real, stable sample.
  assign stable = vld_q[2] && (sync_q == prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= '0;
      sync_q       <= '0;
      prev_q       <= '0;
      acc_q        <= '0;
      vld_q        <= '0;
      first_seen_q <= 1'b0;
      change_q     <= 1'b0;
    end else begin
      meta_q   <= din_i;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      vld_q    <= {vld_q[1:0], 1'b1};
      change_q <= stable && first_seen_q && (sync_q[CW-1:0] != acc_q[CW-1:0]);
      if (stable) begin
        acc_q        <= sync_q;
        first_seen_q <= 1'b1;
      end
    end
  end

  assign value_o  = acc_q;
  assign change_o = change_q;

endmodule

// File: rtl/hourly_chime.sv
// Hourly chime: four low beeps at xx:59:51/53/55/57 and one high beep at xx:00:00 on the speaker.
// Time and control inputs are asynchronous and are synchronised here before the beep FSM sees them.
module hourly_chime
  import hourly_chime_pkg::*;
#(
  parameter int BEEP_CYCLES = 512,
  parameter int LO_HALF     = 4,
  parameter int HI_HALF     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] minute,
  input  logic [6:0] second,
  input  logic       chime_en,
  input  logic       adj_active,
  output logic       speaker,
  output logic       busy
);

  localparam int            DW       = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [DW-1:0] DUR_LAST = DW'(BEEP_CYCLES - 1);
  localparam logic [2:0]    LO_LAST  = 3'(LO_HALF - 1);
  localparam logic [2:0]    HI_LAST  = 3'(HI_HALF - 1);

  logic [1:0]    en_sync_q;
  logic [1:0]    adj_sync_q;
  logic          allow;
  logic [13:0]   time_acc;
  logic          time_evt;
  chime_state_t  trig;
  logic          trig_vld;
  chime_state_t  state_q, state_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [2:0]    tone_q, tone_d;
  logic [2:0]    tone_last;
  logic          spk_q, spk_d;
  logic          busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync_q  <= '0;
      adj_sync_q <= '0;
    end else begin
      en_sync_q  <= {en_sync_q[0], chime_en};
      adj_sync_q <= {adj_sync_q[0], adj_active};
    end
  end

  assign allow = en_sync_q[1] && !adj_sync_q[1];

  // Only the seconds field raises the change pulse; minute is sampled alongside it.
  hourly_chime_bcd_sync_stable #(
    .W  (14),
    .CW (7)
  ) u_time_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_i    ({minute, second}),
    .value_o  (time_acc),
    .change_o (time_evt)
  );

  assign trig     = chime_trigger(time_acc[13:7], time_acc[6:0]);
  assign trig_vld = time_evt && allow && (trig != IDLE);

  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    tone_d    = tone_q;
    spk_d     = spk_q;
    tone_last = (state_q == BEEP_HI) ? HI_LAST : LO_LAST;
    case (state_q)
      IDLE: begin
        spk_d = 1'b0;
        if (trig_vld) begin
          state_d = trig;
          dur_d   = '0;
          tone_d  = '0;
        end
      end
      BEEP_LO, BEEP_HI: begin
        // Disable beats a fresh trigger, which beats the natural end of the beep.
        if (!allow) begin
          state_d = IDLE;
          spk_d   = 1'b0;
        end else if (trig_vld) begin
          state_d = trig;
          dur_d   = '0;
          tone_d  = '0;
          spk_d   = 1'b0;
        end else if (dur_q == DUR_LAST) begin
          state_d = IDLE;
          spk_d   = 1'b0;
        end else begin
          dur_d = dur_q + 1'b1;
          if (tone_q == tone_last) begin
            tone_d = '0;
            spk_d  = !spk_q;
          end else begin
            tone_d = tone_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        spk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dur_q   <= '0;
      tone_q  <= '0;
      spk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      spk_q   <= spk_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign speaker = spk_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_hourly_chime.sv
// Randomised scoreboard bench for hourly_chime: expected beeps are queued as stimulus is applied,
// and a monitor measures each busy window (start, length, speaker rises, tone spacing) against them.
module tb_hourly_chime;

  localparam int BEEP = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] minute = 7'h59;
  logic [6:0] second = 7'h50;
  logic       chime_en = 1'b0;
  logic       adj_active = 1'b0;
  logic       speaker;
  logic       busy;

  hourly_chime dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .minute     (minute),
    .second     (second),
    .chime_en   (chime_en),
    .adj_active (adj_active),
    .speaker    (speaker),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One expected busy window; a restart folds the earlier tone into pre_rises.
  typedef struct {
    int start;
    int seg_start;
    int half;
    int pre_rises;
    int end_t;
  } exp_t;

  exp_t       expq[$];
  int         m_live_end = -1;
  logic [6:0] m_acc_ss = 7'h00;
  bit         m_en = 1'b0;
  bit         m_adj = 1'b0;

  // Rising speaker edges at seg_start + h + 2h*j that fall strictly inside p cycles.
  function automatic int rises_in(input int p, input int h);
    if (p <= h) return 0;
    return (p - h - 1) / (2 * h) + 1;
  endfunction

  function automatic int trig_half(input logic [6:0] mm, input logic [6:0] ss);
    if (mm == 7'h59 && (ss == 7'h51 || ss == 7'h53 || ss == 7'h55 || ss == 7'h57)) return 4;
    if (mm == 7'h00 && ss == 7'h00) return 2;
    return 0;
  endfunction

  function automatic logic [6:0] lo_sec(input int idx);
    logic [7:0] v;
    v = 8'h51 + 8'(2 * idx);
    return v[6:0];
  endfunction

  task automatic start_beep(input int s, input int h);
    exp_t e;
    if (expq.size() > 0 && s <= m_live_end) begin
      e = expq.pop_back();
      e.pre_rises += rises_in(s - e.seg_start, e.half);
      e.seg_start = s;
      e.half      = h;
      e.end_t     = s + BEEP;
      expq.push_back(e);
    end else begin
      e.start     = s;
      e.seg_start = s;
      e.half      = h;
      e.pre_rises = 0;
      e.end_t     = s + BEEP;
      expq.push_back(e);
    end
    m_live_end = s + BEEP;
  endtask

  task automatic truncate(input int e_edge);
    exp_t e;
    if (expq.size() > 0 && m_live_end > e_edge) begin
      e = expq.pop_back();
      e.end_t = e_edge;
      expq.push_back(e);
      m_live_end = e_edge;
    end
  endtask

  task automatic set_time(input logic [6:0] mm, input logic [6:0] ss, input int gap);
    int h;
    @(negedge clk);
    minute = mm;
    second = ss;
    if (ss != m_acc_ss && m_en && !m_adj) begin
      h = trig_half(mm, ss);
      if (h != 0) start_beep(cyc + 5, h);
    end
    m_acc_ss = ss;
    repeat (gap) @(negedge clk);
  endtask

  task automatic set_enables(input bit en, input bit adj, input int gap);
    @(negedge clk);
    chime_en   = en;
    adj_active = adj;
    if (!en || adj) truncate(cyc + 3);
    m_en  = en;
    m_adj = adj;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input logic [6:0] mm, input logic [6:0] ss);
    @(negedge clk);
    rst_n  = 1'b0;
    minute = mm;
    second = ss;
    truncate(cyc + 1);
    #1;
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    m_acc_ss = ss;
    repeat (12) @(negedge clk);
    check("post_rst_busy", busy, 0);
  endtask

  task automatic glitch(input int n);
    logic [6:0] mm0, ss0;
    mm0 = minute;
    ss0 = second;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      minute = (i % 2 == 0) ? 7'h59 : 7'h00;
      second = (i % 2 == 0) ? 7'h51 : 7'h00;
    end
    @(negedge clk);
    minute = mm0;
    second = ss0;
    repeat (40) @(negedge clk);
  endtask

  initial begin : monitor
    bit   prev_busy;
    bit   prev_spk;
    int   st, rises, last_rise, spacing, fin;
    exp_t e;
    prev_busy = 1'b0;
    prev_spk  = 1'b0;
    st = 0; rises = 0; last_rise = -1; spacing = -1;
    forever begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) begin
        st = cyc; rises = 0; last_rise = -1; spacing = -1;
      end
      if (busy && speaker && !prev_spk) begin
        if (last_rise >= 0) spacing = cyc - last_rise;
        last_rise = cyc;
        rises++;
      end
      if (!busy && prev_busy) begin
        check("spk_off_at_end", speaker, 0);
        check("beep_expected", (expq.size() > 0) ? 1 : 0, 1);
        if (expq.size() > 0) begin
          e   = expq.pop_front();
          fin = rises_in(e.end_t - e.seg_start, e.half);
          check("beep_start", st, e.start);
          check("beep_len", cyc - st, e.end_t - e.start);
          check("beep_rises", rises, e.pre_rises + fin);
          if (fin >= 2) check("tone_period", spacing, 2 * e.half);
        end
      end
      prev_busy = busy;
      prev_spk  = speaker;
    end
  end

  initial begin : stim
    int r, g;
    do_reset(7'h59, 7'h50);
    set_enables(1'b1, 1'b0, 10);

    // One low beep, then the full 59:51..00:00 sequence.
    for (int i = 1; i <= 9; i++) set_time(7'h59, 7'(8'h50 + 8'(i)), 600);
    set_time(7'h00, 7'h00, 600);

    // Value held through reset is only loaded, never beeps.
    do_reset(7'h59, 7'h51);
    set_time(7'h59, 7'h53, 600);

    // Adjust cuts a beep short and blocks the next trigger.
    set_time(7'h59, 7'h55, 200);
    set_enables(1'b1, 1'b1, 50);
    set_time(7'h59, 7'h57, 600);
    set_enables(1'b1, 1'b0, 20);

    // Unstable inputs never produce an event.
    glitch(60);

    // Disabled chime at the top of the hour is silent.
    set_enables(1'b0, 1'b0, 20);
    set_time(7'h00, 7'h00, 600);
    set_enables(1'b1, 1'b0, 20);

    // Restart mid-beep with the high tone, then reset in the middle of a beep.
    set_time(7'h59, 7'h57, 300);
    set_time(7'h00, 7'h00, 600);
    set_time(7'h59, 7'h51, 100);
    do_reset(7'h59, 7'h51);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      g = $urandom_range(10, 600);
      case (r)
        0, 1, 2, 3: set_time(7'h59, lo_sec($urandom_range(0, 3)), g);
        4:          set_time(7'h00, 7'h00, g);
        5:          set_time(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), g);
        6:          set_time(7'h59, 7'(8'h5A + 8'($urandom_range(0, 5))), g);
        7:          set_enables($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, g);
        default:    set_time(7'h59, 7'(8'h50 + 8'($urandom_range(0, 9))), g);
      endcase
    end

    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check("drain_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("expected_left", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
